vmu_seq_ctrl: RTL
=================

Name: vmu_seq_ctrl

Overview:
Sequencer that drives the VMU's SEQ-side interface. It accepts one instruction at a time from the instruction queue (valid/ready). Config instructions are issued as one-cycle config ops. Load/store instructions are expanded into a beat-counted run: op_vld is asserted on beat 0, cnt steps once per cycle to the last beat, then the block drains the VMU pipeline and pulses done. The block keeps a shadow VLEN so its beat count matches the VMU's.

Parameters:
CONFIG_OP_WIDTH, 2, config opcode width (00 NONE, 01 VLEN, 10 MODQ, 11 MODIQ)
LSU_OP_WIDTH, 4, per-LSU opcode width
SCALAR_WIDTH, 32, scalar width
NUM_LSU, 4, number of LSUs; LS buses are packed, LSU k in bits [k*W +: W]
CNT_WIDTH, 8, beat counter width
BEAT_SHIFT, 8, log2(NUM_LANE*LANE_DATA_WIDTH); beats = vlen >> BEAT_SHIFT
DRAIN_CYCLES, 2, idle cycles after last beat before done (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  reset
i_inst_vld  in  1  instruction valid
o_inst_rdy  out  1  instruction ready
i_inst_op_config  in  CONFIG_OP_WIDTH  config opcode; NONE means load/store
i_inst_scalar_config  in  SCALAR_WIDTH  config value
i_inst_op_ls  in  NUM_LSU*LSU_OP_WIDTH  per-LSU opcodes
i_inst_scalar_ls  in  NUM_LSU*SCALAR_WIDTH  per-LSU scalars (base address)
o_seq_vmu_op_vld  out  1  op valid to VMU
o_seq_vmu_cnt  out  CNT_WIDTH  beat index
o_seq_vmu_op_config  out  CONFIG_OP_WIDTH  config opcode to VMU
o_seq_vmu_scalar_config  out  SCALAR_WIDTH  config value to VMU
o_seq_vmu_op_ls  out  NUM_LSU*LSU_OP_WIDTH  LS opcodes to VMU
o_seq_vmu_scalar_ls  out  NUM_LSU*SCALAR_WIDTH  LS scalars to VMU
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse when an LS instruction retires

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - All registered outputs 0; state IDLE.
  - vlen_r = 1024.
  - o_inst_rdy = 0 while rst is high.
  - A reset asserted mid-operation aborts the run: the next cycle shows IDLE, all outputs 0, vlen_r = 1024.
- o_inst_rdy = (state==IDLE) && !rst, combinational. Accept = i_inst_vld && o_inst_rdy.
- Payload is captured only on accept. Input changes while rdy is low are ignored.
- FSM states: IDLE, CFG, RUN, DRAIN.
- IDLE:
  - Accept with op_config != NONE -> CFG.
  - Accept with op_config == NONE -> RUN.
  - Otherwise stay IDLE.
- CFG (exactly 1 cycle, at accept cycle T+1):
  - op_vld = 1; op_config and scalar_config carry the captured values; op_ls and scalar_ls = 0; cnt = 0.
  - If the opcode is VLEN, vlen_r <= scalar_config at the end of this cycle.
  - MODQ and MODIQ do not change vlen_r.
  - Next state IDLE, so there is a minimum one-cycle bubble between instructions.
- RUN (starts at T+1):
  - On accept, last_cnt is latched from the current vlen_r:
    - beats = vlen_r >> BEAT_SHIFT.
    - beats == 0 -> treated as 1.
    - beats > 2^CNT_WIDTH -> saturated to 2^CNT_WIDTH.
    - last_cnt = beats - 1.
  - cnt = 0 on the first RUN cycle and increments by 1 each cycle.
  - op_vld = 1 only on the first RUN cycle.
  - op_config = NONE and scalar_config = 0 for the whole run.
  - op_ls and scalar_ls hold the captured values for the whole run.
  - When cnt == last_cnt: go to DRAIN if DRAIN_CYCLES > 0, else go to IDLE with o_done = 1 on that transition cycle.
- DRAIN:
  - Counts DRAIN_CYCLES cycles.
  - cnt holds last_cnt; op_ls and scalar_ls are cleared to 0.
  - On the final DRAIN cycle: o_done = 1 and next state is IDLE.
- o_done is registered alongside the state and asserted only in the cycle it retires. It is never asserted for config instructions.
- Outputs in IDLE: op_vld, op_ls, scalar_ls, op_config and scalar_config are all 0. cnt retains its last value (no functional meaning).
- Timing for an LS instruction: done occurs at T + beats + DRAIN_CYCLES (the last RUN or DRAIN cycle). The first cycle with rdy high again is the following cycle.

Test Plan:
- Reset: after rst is released, rdy = 1, busy = 0, all outputs 0; then an LS op with default VLEN 1024 -> 4 beats (cnt 0,1,2,3), op_vld only at cnt 0.
- Config VLEN = 512 accepted at T -> op_vld = 1, op_config = 01, scalar = 512 at T+1; rdy is 0 at T+1 and 1 at T+2. Following LS op -> cnt 0..1; done 2+2 cycles after its accept.
- VLEN = 100 (beats 0) -> LS op runs a single beat, cnt = 0; done at accept + 1 + 2.
- VLEN = 0x20000 (beats 512 > 256) -> saturates; cnt runs 0..255 and wraps nowhere.
- Reset pulsed when cnt = 2 -> next cycle IDLE, outputs 0, vlen_r = 1024, no o_done.
- i_inst_vld held high with the payload changing every cycle -> only the payloads present in IDLE cycles are issued; MODQ does not alter beat count; DRAIN_CYCLES = 0 build gives done on the last RUN cycle.

Source files
------------

// File: rtl/vmu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vmu_seq_ctrl
//
// Purpose:
//   Drives the VMU's SEQ-side interface. It accepts one instruction at a time
//   from the instruction queue using a valid/ready handshake.
//   - A config instruction (op_config != NONE) is issued as a single-cycle
//     config op.
//   - A load/store instruction (op_config == NONE) is expanded into a run of
//     beats. cnt steps from 0 to the last beat, and op_vld is high only on
//     beat 0. The block then waits DRAIN_CYCLES cycles for the VMU pipeline
//     to drain and pulses o_done.
//   The block keeps a shadow copy of VLEN so that its beat count matches the
//   VMU's beat count.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   i_inst_vld / o_inst_rdy  instruction handshake (ready only while IDLE)
//   i_inst_op_config         config opcode (00 NONE, 01 VLEN, 10 MODQ, 11 MODIQ)
//   i_inst_scalar_config     config value
//   i_inst_op_ls             packed per-LSU opcodes (LSU k at [k*W +: W])
//   i_inst_scalar_ls         packed per-LSU scalars (base addresses)
//   o_seq_vmu_*              op valid, beat index and payload to the VMU
//   o_busy                   high whenever the FSM is not IDLE
//   o_done                   one-cycle pulse on the cycle an LS instruction retires
// -----------------------------------------------------------------------------
module vmu_seq_ctrl #(
    parameter int CONFIG_OP_WIDTH = 2,
    parameter int LSU_OP_WIDTH    = 4,
    parameter int SCALAR_WIDTH    = 32,
    parameter int NUM_LSU         = 4,
    parameter int CNT_WIDTH       = 8,
    parameter int BEAT_SHIFT      = 8,
    parameter int DRAIN_CYCLES    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_inst_vld,
    output logic                              o_inst_rdy,
    input  logic [CONFIG_OP_WIDTH-1:0]        i_inst_op_config,
    input  logic [SCALAR_WIDTH-1:0]           i_inst_scalar_config,
    input  logic [NUM_LSU*LSU_OP_WIDTH-1:0]   i_inst_op_ls,
    input  logic [NUM_LSU*SCALAR_WIDTH-1:0]   i_inst_scalar_ls,
    output logic                              o_seq_vmu_op_vld,
    output logic [CNT_WIDTH-1:0]              o_seq_vmu_cnt,
    output logic [CONFIG_OP_WIDTH-1:0]        o_seq_vmu_op_config,
    output logic [SCALAR_WIDTH-1:0]           o_seq_vmu_scalar_config,
    output logic [NUM_LSU*LSU_OP_WIDTH-1:0]   o_seq_vmu_op_ls,
    output logic [NUM_LSU*SCALAR_WIDTH-1:0]   o_seq_vmu_scalar_ls,
    output logic                              o_busy,
    output logic                              o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CFG   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CONFIG_OP_WIDTH-1:0] OP_NONE = '0;
    localparam logic [CONFIG_OP_WIDTH-1:0] OP_VLEN = CONFIG_OP_WIDTH'(1);
    localparam logic [SCALAR_WIDTH-1:0]    VLEN_RST  = SCALAR_WIDTH'(1024);
    localparam logic [SCALAR_WIDTH-1:0]    MAX_BEATS = SCALAR_WIDTH'(1) << CNT_WIDTH;

    // Drain counter runs 0 .. DRAIN_LAST. The counter keeps a width of at
    // least 1 even when there is no drain phase (DRAIN_CYCLES == 0).
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int DRAIN_W    = (DRAIN_LAST > 0) ? $clog2(DRAIN_LAST + 1) : 1;

    // Index of the last beat for a given VLEN.
    // - A run always has at least one beat (zero beats become one beat).
    // - A run never has more beats than the counter can index
    //   (the count saturates at 2^CNT_WIDTH).
    function automatic logic [CNT_WIDTH-1:0] last_beat(input logic [SCALAR_WIDTH-1:0] vlen);
        logic [SCALAR_WIDTH-1:0] beats;
        beats = vlen >> BEAT_SHIFT;
        if (beats == '0) begin
            return '0;
        end else if (beats >= MAX_BEATS) begin
            return '1;
        end else begin
            return CNT_WIDTH'(beats - SCALAR_WIDTH'(1));
        end
    endfunction

    state_t                            state_q, state_d;
    logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]              last_q, last_d;
    logic [DRAIN_W-1:0]                drain_q, drain_d;
    logic [SCALAR_WIDTH-1:0]           vlen_q, vlen_d;
    logic                              done_q, done_d;

    // Captured instruction payload. It is only visible through state-gated
    // outputs, so it needs no reset.
    logic [CONFIG_OP_WIDTH-1:0]        op_config_q;
    logic [SCALAR_WIDTH-1:0]           scalar_config_q;
    logic [NUM_LSU*LSU_OP_WIDTH-1:0]   op_ls_q;
    logic [NUM_LSU*SCALAR_WIDTH-1:0]   scalar_ls_q;

    logic                              accept;

    assign o_inst_rdy = (state_q == S_IDLE) && !rst;
    assign accept     = i_inst_vld && o_inst_rdy;

    // ---- State register ----------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            drain_q <= '0;
            vlen_q  <= VLEN_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            drain_q <= drain_d;
            vlen_q  <= vlen_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_config_q     <= i_inst_op_config;
            scalar_config_q <= i_inst_scalar_config;
            op_ls_q         <= i_inst_op_ls;
            scalar_ls_q     <= i_inst_scalar_ls;
        end
    end

    // ---- Next-state logic ----------------------------------------------------
    // done_d anticipates the retiring cycle, so that done_q is high exactly
    // during the last RUN cycle (when there is no drain) or the last DRAIN cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        drain_d = drain_q;
        vlen_d  = vlen_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (i_inst_op_config != OP_NONE) begin
                        state_d = S_CFG;
                    end else begin
                        state_d = S_RUN;
                        last_d  = last_beat(vlen_q);
                        done_d  = (DRAIN_CYCLES == 0) && (last_beat(vlen_q) == '0);
                    end
                end
            end
            S_CFG: begin
                state_d = S_IDLE;
                if (op_config_q == OP_VLEN) begin
                    vlen_d = scalar_config_q;
                end
            end
            S_RUN: begin
                if (cnt_q == last_q) begin
                    if (DRAIN_CYCLES > 0) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                        done_d  = (DRAIN_CYCLES == 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_WIDTH'(1);
                    done_d = (DRAIN_CYCLES == 0) && (cnt_q + CNT_WIDTH'(1) == last_q);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                    done_d  = (drain_q + DRAIN_W'(1) == DRAIN_W'(DRAIN_LAST));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---- Output logic --------------------------------------------------------
    assign o_seq_vmu_cnt = cnt_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;

    always_comb begin
        o_seq_vmu_op_vld        = 1'b0;
        o_seq_vmu_op_config     = '0;
        o_seq_vmu_scalar_config = '0;
        o_seq_vmu_op_ls         = '0;
        o_seq_vmu_scalar_ls     = '0;
        case (state_q)
            S_CFG: begin
                o_seq_vmu_op_vld        = 1'b1;
                o_seq_vmu_op_config     = op_config_q;
                o_seq_vmu_scalar_config = scalar_config_q;
            end
            S_RUN: begin
                // cnt never wraps inside a run, so cnt == 0 marks beat 0 only.
                o_seq_vmu_op_vld    = (cnt_q == '0);
                o_seq_vmu_op_ls     = op_ls_q;
                o_seq_vmu_scalar_ls = scalar_ls_q;
            end
            default: begin
            end
        endcase
    end

endmodule
